// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl
// Description : Sample-rate divider and MAC sequencer for a polyphase FIR.
//               Each sample strobe launches one clear/MAC/output pass.
//               Coefficient updates are arbitrated so they never overlap
//               a MAC pass.
//               Optional macro FIR_CTRL_DROP_CNT_EN builds a saturating
//               counter of samples skipped while the coefficient bus is
//               granted. Without the macro, oDropCnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl #(
   parameter int DIV  = 20,  // clock cycles per sample period, 14..255
   parameter int TAPS = 10   // taps per MAC pass, 1..15, DIV >= TAPS+4
) (
   input  logic       iClk12M,
   input  logic       iRst,
   input  logic       iEnable,
   input  logic       iCoeffReq,
   input  logic       iCoeffDone,
   output logic       oCoeffGnt,
   output logic       oEnSample600k,
   output logic       oEnDelay,
   output logic       oMacClr,
   output logic       oEnMac,
   output logic [3:0] oTapAddr,
   output logic       oOutValid,
   output logic       oBusy,
   output logic [7:0] oDropCnt
);

   localparam logic [7:0] c_CNT_LAST = 8'(DIV - 1);
   localparam logic [3:0] c_TAP_LAST = 4'(TAPS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_MAC    = 3'd2,
      S_DONE   = 3'd3,
      S_UPDATE = 3'd4
   } state_t;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_mac_clr;
   logic       r_en_mac;
   logic [3:0] r_tap;
   logic       r_out_valid;
   logic       r_gnt;
   logic       r_busy;
   logic       w_strobe;

   // The strobe is decoded straight from the divider, so it keeps running
   // in every FSM state, including during a coefficient update.
   assign w_strobe      = iEnable && (r_cnt == c_CNT_LAST);
   assign oEnSample600k = w_strobe;
   assign oEnDelay      = w_strobe;

   assign oMacClr   = r_mac_clr;
   assign oEnMac    = r_en_mac;
   assign oTapAddr  = r_tap;
   assign oOutValid = r_out_valid;
   assign oCoeffGnt = r_gnt;
   assign oBusy     = r_busy;

   // Sample divider: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         r_cnt <= 8'd0;
      end else if (!iEnable) begin
         r_cnt <= 8'd0;
      end else if (r_cnt == c_CNT_LAST) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Pass/update sequencer; every output is registered alongside its state.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         r_state     <= S_IDLE;
         r_mac_clr   <= 1'b0;
         r_en_mac    <= 1'b0;
         r_tap       <= 4'd0;
         r_out_valid <= 1'b0;
         r_gnt       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_mac_clr   <= 1'b0;
         r_en_mac    <= 1'b0;
         r_tap       <= 4'd0;
         r_out_valid <= 1'b0;
         r_gnt       <= 1'b0;
         r_busy      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A sample outranks a pending request; the request is
               // simply seen again on the next strobe-free IDLE cycle.
               if (w_strobe) begin
                  r_state   <= S_CLR;
                  r_mac_clr <= 1'b1;
                  r_busy    <= 1'b1;
               end else if (iCoeffReq) begin
                  r_state <= S_UPDATE;
                  r_gnt   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_CLR: begin
               r_state  <= S_MAC;
               r_en_mac <= 1'b1;
               r_busy   <= 1'b1;
            end
            S_MAC: begin
               if (r_tap == c_TAP_LAST) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_en_mac <= 1'b1;
                  r_tap    <= r_tap + 4'd1;
               end
               r_busy <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            S_UPDATE: begin
               if (iCoeffDone) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gnt  <= 1'b1;
                  r_busy <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef FIR_CTRL_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   // Count samples that arrive while the updater owns the coefficient bus.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         r_drop_cnt <= 8'd0;
      end else if ((r_state == S_UPDATE) && w_strobe && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign oDropCnt = r_drop_cnt;
`else
   assign oDropCnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_ctrl
// Description : Self-checking bench for fir_ctrl. A timeline model (divider
//               phase plus position inside the current pass) predicts every
//               output each cycle. Directed steps probe the timing corners,
//               and a randomized tail follows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_ctrl;

   localparam int DIV  = 20;
   localparam int TAPS = 10;
`ifdef FIR_CTRL_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       iRst = 1'b1;
   logic       iEnable = 1'b0;
   logic       iCoeffReq = 1'b0;
   logic       iCoeffDone = 1'b0;
   logic       oCoeffGnt, oEnSample600k, oEnDelay, oMacClr, oEnMac;
   logic       oOutValid, oBusy;
   logic [3:0] oTapAddr;
   logic [7:0] oDropCnt;

   fir_ctrl #(.DIV(DIV), .TAPS(TAPS)) dut (
      .iClk12M      (clk),
      .iRst         (iRst),
      .iEnable      (iEnable),
      .iCoeffReq    (iCoeffReq),
      .iCoeffDone   (iCoeffDone),
      .oCoeffGnt    (oCoeffGnt),
      .oEnSample600k(oEnSample600k),
      .oEnDelay     (oEnDelay),
      .oMacClr      (oMacClr),
      .oEnMac       (oEnMac),
      .oTapAddr     (oTapAddr),
      .oOutValid    (oOutValid),
      .oBusy        (oBusy),
      .oDropCnt     (oDropCnt)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit chk_on = 1'b0;

   // Model: divider phase, activity (0 idle, 1 pass, 2 update),
   // position within a pass (0 clear, 1..TAPS taps, TAPS+1 output), drop total.
   int m_cnt = 0;
   int m_mode = 0;
   int m_pos = 0;
   int m_drop = 0;

   // Last sampled DUT outputs
   logic       s_strobe, s_clr, s_mac, s_valid, s_gnt, s_busy;
   logic [3:0] s_addr;
   logic [7:0] s_drop;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] predict();
      logic       e_str, e_clr, e_mac, e_valid, e_gnt, e_busy;
      logic [3:0] e_addr;
      logic [7:0] e_drop;
      e_str   = iEnable && (m_cnt == DIV - 1);
      e_clr   = (m_mode == 1) && (m_pos == 0);
      e_mac   = (m_mode == 1) && (m_pos >= 1) && (m_pos <= TAPS);
      e_addr  = e_mac ? 4'(m_pos - 1) : 4'd0;
      e_valid = (m_mode == 1) && (m_pos == TAPS + 1);
      e_gnt   = (m_mode == 2);
      e_busy  = (m_mode != 0);
      e_drop  = DROP_EN ? 8'(m_drop) : 8'd0;
      return {e_str, e_str, e_clr, e_mac, e_addr, e_valid, e_gnt, e_busy, e_drop};
   endfunction

   task automatic model_step();
      bit str;
      str = iEnable && (m_cnt == DIV - 1);
      if (iRst) begin
         m_cnt = 0; m_mode = 0; m_pos = 0; m_drop = 0;
      end else begin
         if (m_mode == 2 && str && m_drop < 255) m_drop++;
         case (m_mode)
            0: if (str) begin m_mode = 1; m_pos = 0; end
               else if (iCoeffReq) m_mode = 2;
            1: if (m_pos == TAPS + 1) m_mode = 0; else m_pos++;
            default: if (iCoeffDone) m_mode = 0;
         endcase
         m_cnt = iEnable ? (m_cnt + 1) % DIV : 0;
      end
   endtask

   // One clock: compare mid-cycle, then advance the model at the edge.
   task automatic tick();
      logic [18:0] obs;
      logic [18:0] exp;
      @(negedge clk);
      obs = {oEnSample600k, oEnDelay, oMacClr, oEnMac, oTapAddr, oOutValid,
             oCoeffGnt, oBusy, oDropCnt};
      exp = predict();
      s_strobe = oEnSample600k; s_clr = oMacClr; s_mac = oEnMac; s_addr = oTapAddr;
      s_valid = oOutValid; s_gnt = oCoeffGnt; s_busy = oBusy; s_drop = oDropCnt;
      if (chk_on) check($sformatf("cycle%0d", cyc), 32'(obs), 32'(exp));
      @(posedge clk);
      model_step();
      chk_on = 1'b1;
      cyc++;
      #1;
   endtask

   initial begin
      int first_s, second_s, first_clr, first_mac, last_mac, first_v;
      int ns, guard, no_mac, lat, nv;

      // Reset state
      repeat (3) tick();
      check("reset_outputs", 32'({s_strobe, s_clr, s_mac, s_addr, s_valid, s_gnt, s_busy, s_drop}), 32'd0);

      // Release with enable: strobe/pass timeline from cycle 1
      iRst = 1'b0; iEnable = 1'b1;
      first_s = 0; second_s = 0; first_clr = 0; first_mac = 0; last_mac = 0; first_v = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (s_strobe) begin
            if (first_s == 0) first_s = c; else if (second_s == 0) second_s = c;
         end
         if (s_clr && first_clr == 0) first_clr = c;
         if (s_mac) begin
            if (first_mac == 0) first_mac = c;
            last_mac = c;
         end
         if (s_valid && first_v == 0) first_v = c;
      end
      check("first_strobe_cycle", first_s, 20);
      check("second_strobe_cycle", second_s, 40);
      check("first_clr_cycle", first_clr, 21);
      check("first_mac_cycle", first_mac, 22);
      check("last_mac_cycle", last_mac, 31);
      check("first_valid_cycle", first_v, 32);

      // Coefficient update holding across three strobes
      repeat (12) tick();
      iCoeffReq = 1'b1;
      tick();
      check("gnt_same_cycle", s_gnt, 1'b0);
      tick();
      check("gnt_next_cycle", s_gnt, 1'b1);
      ns = 0; guard = 0; no_mac = 0;
      while (ns < 3 && guard < 200) begin
         tick();
         guard++;
         if (s_mac) no_mac++;
         if (s_strobe) begin
            ns++;
            check("gnt_during_strobe", s_gnt, 1'b1);
         end
      end
      check("three_strobes_seen", ns, 3);
      iCoeffDone = 1'b1;
      tick();
      iCoeffDone = 1'b0; iCoeffReq = 1'b0;
      check("drop_after_three", s_drop, DROP_EN ? 3 : 0);
      check("no_mac_in_update", no_mac, 0);
      tick();
      check("idle_after_done", 32'({s_gnt, s_busy}), 32'd0);

      // Request arriving with a strobe waits for the full pass
      guard = 0;
      while (!(m_mode == 0 && m_cnt == DIV - 1) && guard < 100) begin tick(); guard++; end
      iCoeffReq = 1'b1;
      tick();
      check("strobe_with_req", s_strobe, 1'b1);
      lat = 0;
      do begin tick(); lat++; end while (!s_valid && lat < 30);
      check("strobe_to_valid_latency", lat, TAPS + 2);
      tick();
      check("gnt_low_after_valid", 32'({s_gnt, s_busy}), 32'd0);
      tick();
      check("gnt_after_pass", s_gnt, 1'b1);
      iCoeffDone = 1'b1;
      tick();
      iCoeffDone = 1'b0; iCoeffReq = 1'b0;
      tick();

      // Reset in the middle of a MAC pass at tap 5
      guard = 0;
      while (!(m_mode == 1 && m_pos == 6) && guard < 100) begin tick(); guard++; end
      iRst = 1'b1;
      tick();
      check("tap5_before_reset", 32'({s_mac, s_addr}), 32'h15);
      iRst = 1'b0;
      tick();
      check("outputs_after_reset", 32'({s_strobe, s_clr, s_mac, s_addr, s_valid, s_gnt, s_busy, s_drop}), 32'd0);
      lat = 1;
      while (!s_strobe && lat < 40) begin tick(); lat++; end
      check("strobe_after_reset", lat, 20);

      // Long update: drop counter saturation
      iCoeffReq = 1'b1;
      guard = 0;
      while (!s_gnt && guard < 100) begin tick(); guard++; end
      check("long_update_granted", s_gnt, 1'b1);
      ns = 0; guard = 0;
      while (ns < 300 && guard < 300 * DIV + 100) begin
         tick(); guard++;
         if (s_strobe) ns++;
      end
      check("drop_saturated", s_drop, DROP_EN ? 255 : 0);
      iCoeffDone = 1'b1;
      tick();
      iCoeffDone = 1'b0; iCoeffReq = 1'b0;
      tick();

      // Enable dropped mid-MAC: pass completes, strobes stop
      guard = 0;
      while (!(m_mode == 1 && m_pos == 3) && guard < 100) begin tick(); guard++; end
      iEnable = 1'b0;
      nv = 0; ns = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (s_valid) nv++;
         if (s_strobe) ns++;
      end
      check("valid_after_enable_off", nv, 1);
      check("no_strobe_enable_off", ns, 0);

      // Randomized traffic against the model
      iEnable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         iEnable = ($urandom_range(0, 99) < 98);
         iRst = ($urandom_range(0, 999) == 0);
         iCoeffDone = 1'b0;
         if (!iCoeffReq && $urandom_range(0, 49) == 0) iCoeffReq = 1'b1;
         if (s_gnt && $urandom_range(0, 7) == 0) begin
            iCoeffDone = 1'b1;
            iCoeffReq = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            iCoeffDone = 1'b1;
         end
         tick();
      end
      iRst = 1'b0; iCoeffDone = 1'b0; iCoeffReq = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
